// File: rtl/mmio_pkg.sv
// Shared constants for the UART MMIO responder: register map, STATUS bit
// positions and the TX sequencer state encoding.
package mmio_pkg;

    localparam logic [15:0] MMIO_REGION = 16'h0003;

    localparam logic [7:0] REG_TXDATA = 8'h00;
    localparam logic [7:0] REG_RXDATA = 8'h04;
    localparam logic [7:0] REG_STATUS = 8'h08;
    localparam logic [7:0] REG_CTRL   = 8'h0C;
    localparam logic [7:0] REG_BAUD   = 8'h10;

    localparam int ST_TX_FULL   = 0;
    localparam int ST_TX_EMPTY  = 1;
    localparam int ST_RX_EMPTY  = 2;
    localparam int ST_RX_FULL   = 3;
    localparam int ST_TX_OVF    = 4;
    localparam int ST_RX_OVF    = 5;
    localparam int ST_RX_UNF    = 6;
    localparam int ST_TX_ACTIVE = 7;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        START     = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } tx_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO. Pointers carry an extra wrap bit so full and empty are
// distinguishable without a separate counter. A push while full succeeds only
// when a pop happens in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     n_reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_pop;
    logic             do_push;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign count   = wr_ptr - rd_ptr;
    assign dout    = mem[rd_ptr[AW-1:0]];
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    // Storage needs no reset: contents are invalidated by the pointer reset.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end

    // Pointer advance.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

endmodule

// File: rtl/mmio_uart_ctrl.sv
// CPU-facing UART register block: TX/RX FIFOs, status/control/baud registers,
// a TX sequencer that hands bytes to the UART core, and a level interrupt.
module mmio_uart_ctrl
    import mmio_pkg::*;
#(
    parameter int          FIFO_DEPTH   = 8,
    parameter logic [15:0] BAUD_DEFAULT = 16'd434
) (
    input  logic        clk,
    input  logic        n_reset,
    input  logic        sel,
    input  logic        rd_en,
    input  logic        wr_en,
    input  logic [7:0]  addr,
    input  logic [31:0] data_in,
    output logic [31:0] data_out,
    output logic        tx_start,
    output logic [7:0]  tx_data,
    input  logic        tx_busy,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic [15:0] baud_tick_max,
    output logic        irq
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [1:0]    rst_pipe;
    logic          rst_n;
    logic [7:0]    off;
    logic          wr_acc, rd_acc;
    logic          tx_push, tx_pop, tx_full, tx_empty;
    logic          rx_pop, rx_full, rx_empty, rx_rd;
    logic [7:0]    tx_dout, rx_dout;
    logic [CW-1:0] tx_cnt, rx_cnt;
    logic          tx_ovf, rx_ovf, rx_unf;
    logic [2:0]    flag_clr;
    logic [1:0]    ctrl;
    logic [31:0]   status, rdata;
    tx_state_e     state;
    logic [1:0]    idle_cnt;
    logic          unused_bits;

    // Reset asserts immediately, releases two clocks after n_reset rises.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) rst_pipe <= 2'b00;
        else          rst_pipe <= {rst_pipe[0], 1'b1};
    end
    assign rst_n = rst_pipe[1];

    assign off         = {addr[7:2], 2'b00};
    assign unused_bits = ^{addr[1:0], data_in[31:16]};
    // A simultaneous read and write is treated as a write only.
    assign wr_acc      = sel & wr_en;
    assign rd_acc      = sel & rd_en & ~wr_en;

    assign tx_push  = wr_acc & (off == REG_TXDATA);
    assign tx_pop   = (state == IDLE) & ~tx_empty & ~tx_busy;
    assign rx_rd    = rd_acc & (off == REG_RXDATA);
    assign rx_pop   = rx_rd & ~rx_empty;
    assign flag_clr = (wr_acc && off == REG_STATUS) ? data_in[6:4] : 3'b000;
    assign tx_start = (state == START);

    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk(clk), .n_reset(rst_n), .push(tx_push), .pop(tx_pop), .din(data_in[7:0]),
        .dout(tx_dout), .full(tx_full), .empty(tx_empty), .count(tx_cnt)
    );

    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk(clk), .n_reset(rst_n), .push(rx_valid), .pop(rx_pop), .din(rx_data),
        .dout(rx_dout), .full(rx_full), .empty(rx_empty), .count(rx_cnt)
    );

    // STATUS word assembly.
    always_comb begin
        status                = '0;
        status[ST_TX_FULL]    = tx_full;
        status[ST_TX_EMPTY]   = tx_empty;
        status[ST_RX_EMPTY]   = rx_empty;
        status[ST_RX_FULL]    = rx_full;
        status[ST_TX_OVF]     = tx_ovf;
        status[ST_RX_OVF]     = rx_ovf;
        status[ST_RX_UNF]     = rx_unf;
        status[ST_TX_ACTIVE]  = (state != IDLE);
        status[15:8]          = 8'(rx_cnt);
        status[23:16]         = 8'(tx_cnt);
    end

    // Read mux; unmapped and write-only offsets return zero.
    always_comb begin
        rdata = '0;
        case (off)
            REG_RXDATA: rdata = {24'h0, rx_empty ? 8'h00 : rx_dout};
            REG_STATUS: rdata = status;
            REG_CTRL:   rdata = {30'h0, ctrl};
            REG_BAUD:   rdata = {16'h0, baud_tick_max};
            default:    rdata = '0;
        endcase
    end

    // Registered read data, held between reads.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      data_out <= '0;
        else if (rd_acc) data_out <= rdata;
    end

    // CTRL and BAUD registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl          <= '0;
            baud_tick_max <= BAUD_DEFAULT;
        end else if (wr_acc) begin
            if (off == REG_CTRL) ctrl          <= data_in[1:0];
            if (off == REG_BAUD) baud_tick_max <= data_in[15:0];
        end
    end

    // Sticky error flags; a set in the same cycle as a clear wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_ovf <= 1'b0;
            rx_ovf <= 1'b0;
            rx_unf <= 1'b0;
        end else begin
            tx_ovf <= (tx_push & tx_full & ~tx_pop)   | (tx_ovf & ~flag_clr[0]);
            rx_ovf <= (rx_valid & rx_full & ~rx_pop)  | (rx_ovf & ~flag_clr[1]);
            rx_unf <= (rx_rd & rx_empty)              | (rx_unf & ~flag_clr[2]);
        end
    end

    // TX sequencer: pop a byte, pulse tx_start, then track the UART busy flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            tx_data  <= '0;
            idle_cnt <= '0;
        end else begin
            case (state)
                IDLE: if (tx_pop) begin
                    tx_data <= tx_dout;
                    state   <= START;
                end
                START: begin
                    idle_cnt <= '0;
                    state    <= WAIT_BUSY;
                end
                // Give up after four quiet cycles: the UART either finished
                // instantly or is not there.
                WAIT_BUSY: begin
                    if (tx_busy)              state    <= WAIT_DONE;
                    else if (idle_cnt == 2'd3) state    <= IDLE;
                    else                      idle_cnt <= idle_cnt + 2'd1;
                end
                WAIT_DONE: if (!tx_busy) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Level interrupt, one cycle behind the conditions.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) irq <= 1'b0;
        else        irq <= (ctrl[0] & ~rx_empty) | (ctrl[1] & tx_empty & (state == IDLE));
    end

endmodule

// File: tb/tb_mmio_uart_ctrl.sv
// Scoreboarded bench for mmio_uart_ctrl: read expectations, TX bytes and RX
// bytes are queued when stimulus is driven and checked when the DUT responds.
module tb_mmio_uart_ctrl;
    import mmio_pkg::*;

    logic        clk = 1'b0;
    logic        n_reset = 1'b0;
    logic        sel = 1'b0, rd_en = 1'b0, wr_en = 1'b0;
    logic [7:0]  addr = '0;
    logic [31:0] data_in = '0;
    logic [31:0] data_out;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic        tx_busy;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data = '0;
    logic [15:0] baud_tick_max;
    logic        irq;

    logic        model_busy = 1'b0;
    logic        force_busy = 1'b0;
    logic        prev_start = 1'b0;
    logic [7:0]  mon_exp;
    int          tests = 0;
    int          fails = 0;
    int          tx_pulses = 0;

    logic [31:0] rd_q[$];
    logic [7:0]  tx_q[$];
    logic [7:0]  rx_q[$];

    assign tx_busy = model_busy | force_busy;

    always #5 clk = ~clk;

    mmio_uart_ctrl #(.FIFO_DEPTH(8), .BAUD_DEFAULT(16'd434)) dut (
        .clk(clk), .n_reset(n_reset), .sel(sel), .rd_en(rd_en), .wr_en(wr_en),
        .addr(addr), .data_in(data_in), .data_out(data_out), .tx_start(tx_start),
        .tx_data(tx_data), .tx_busy(tx_busy), .rx_valid(rx_valid), .rx_data(rx_data),
        .baud_tick_max(baud_tick_max), .irq(irq)
    );

    // UART model: busy rises 2 cycles after tx_start and stays up 10 cycles.
    always begin
        @(negedge clk);
        if (n_reset && tx_start) begin
            repeat (2) @(negedge clk);
            model_busy = 1'b1;
            repeat (10) @(negedge clk);
            model_busy = 1'b0;
        end
    end

    // TX monitor: each tx_start is a single-cycle pulse carrying the next queued byte.
    always @(negedge clk) begin
        if (n_reset && tx_start) begin
            tests++;
            tx_pulses++;
            if (prev_start) begin
                fails++;
                $display("FAIL tx_start_width: tx_start high %0d consecutive cycles, required 1", 2);
            end else if (tx_q.size() == 0) begin
                fails++;
                $display("FAIL tx_unexpected: tx_start with tx_data=%02h, required no pulse", tx_data);
            end else begin
                mon_exp = tx_q.pop_front();
                if (tx_data !== mon_exp) begin
                    fails++;
                    $display("FAIL tx_byte: tx_data=%02h, required %02h", tx_data, mon_exp);
                end
            end
        end
        prev_start <= tx_start;
    end

    task automatic bus_write(input logic [7:0] a, input logic [31:0] d);
        @(negedge clk);
        sel = 1'b1; wr_en = 1'b1; addr = a; data_in = d;
        @(negedge clk);
        sel = 1'b0; wr_en = 1'b0; data_in = '0;
    endtask

    task automatic bus_read(input logic [7:0] a, output logic [31:0] d);
        @(negedge clk);
        sel = 1'b1; rd_en = 1'b1; addr = a;
        @(negedge clk);
        sel = 1'b0; rd_en = 1'b0;
        d = data_out;
    endtask

    task automatic rx_pulse(input logic [7:0] b);
        @(negedge clk);
        rx_valid = 1'b1; rx_data = b;
        rx_q.push_back(b);
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] got, exp;
        repeat (3) @(negedge clk);
        tests++;
        if (data_out !== 32'h0 || tx_start !== 1'b0 || irq !== 1'b0 || baud_tick_max !== 16'd434) begin
            fails++;
            $display("FAIL reset_outputs: data_out=%h tx_start=%b irq=%b baud=%0d, required 0/0/0/434",
                     data_out, tx_start, irq, baud_tick_max);
        end
        n_reset = 1'b1;
        repeat (3) @(negedge clk);
        rd_q.push_back(32'h0000_01B2);
        bus_read(REG_BAUD, got); exp = rd_q.pop_front(); tests++;
        if (got !== exp) begin fails++; $display("FAIL reset_baud: got %h, required %h", got, exp); end
        rd_q.push_back(32'h0000_0006);
        bus_read(REG_STATUS, got); exp = rd_q.pop_front(); tests++;
        if (got !== exp) begin fails++; $display("FAIL reset_status: got %h, required %h", got, exp); end
        tests++;
        if (irq !== 1'b0) begin fails++; $display("FAIL reset_irq: got %b, required 0", irq); end
    endtask

    task automatic test_regs();
        logic [31:0] got, exp;
        bus_write(REG_BAUD, 32'hFFFF_1234);
        tests++;
        if (baud_tick_max !== 16'h1234) begin
            fails++; $display("FAIL baud_port: got %h, required 1234", baud_tick_max);
        end
        rd_q.push_back(32'h0000_1234);
        bus_read(REG_BAUD, got); exp = rd_q.pop_front(); tests++;
        if (got !== exp) begin fails++; $display("FAIL baud_read: got %h, required %h", got, exp); end
        bus_write(REG_CTRL, 32'hFFFF_FFFF);
        rd_q.push_back(32'h0000_0003);
        bus_read(REG_CTRL, got); exp = rd_q.pop_front(); tests++;
        if (got !== exp) begin fails++; $display("FAIL ctrl_read: got %h, required %h", got, exp); end
        rd_q.push_back(32'h0);
        bus_read(8'h20, got); exp = rd_q.pop_front(); tests++;
        if (got !== exp) begin fails++; $display("FAIL unmapped_read: got %h, required %h", got, exp); end
        bus_write(REG_BAUD, 32'h0000_5678);
        rd_q.push_back(32'h0000_5678);
        bus_read(REG_BAUD, got); exp = rd_q.pop_front(); tests++;
        if (got !== exp) begin fails++; $display("FAIL baud_read2: got %h, required %h", got, exp); end
        rd_q.push_back(32'h0);
        bus_read(REG_TXDATA, got); exp = rd_q.pop_front(); tests++;
        if (got !== exp) begin fails++; $display("FAIL txdata_read: got %h, required %h", got, exp); end
        // Prime data_out, then a read+write strobe must leave it alone.
        bus_read(REG_BAUD, got);
        @(negedge clk);
        sel = 1'b1; rd_en = 1'b1; wr_en = 1'b1; addr = REG_CTRL; data_in = 32'h2;
        @(negedge clk);
        sel = 1'b0; rd_en = 1'b0; wr_en = 1'b0;
        tests++;
        if (data_out !== 32'h0000_5678) begin
            fails++; $display("FAIL rdwr_hold: data_out=%h, required 00005678", data_out);
        end
        @(negedge clk);
        tests++;
        if (irq !== 1'b1) begin fails++; $display("FAIL tx_irq: got %b, required 1", irq); end
        rd_q.push_back(32'h0000_0002);
        bus_read(REG_CTRL, got); exp = rd_q.pop_front(); tests++;
        if (got !== exp) begin fails++; $display("FAIL rdwr_write: got %h, required %h", got, exp); end
        bus_write(REG_CTRL, 32'h0);
        bus_write(REG_BAUD, 32'd434);
    endtask

    task automatic test_tx_basic();
        logic [31:0] got, exp;
        tx_q.push_back(8'h41); bus_write(REG_TXDATA, 32'h41);
        tx_q.push_back(8'h42); bus_write(REG_TXDATA, 32'h42);
        for (int i = 0; i < 200 && tx_q.size() != 0; i++) @(negedge clk);
        tests++;
        if (tx_q.size() != 0) begin fails++; $display("FAIL tx_basic_drain: %0d bytes left, required 0", tx_q.size()); end
        repeat (20) @(negedge clk);
        rd_q.push_back(32'h0000_0006);
        bus_read(REG_STATUS, got); exp = rd_q.pop_front(); tests++;
        if (got !== exp) begin fails++; $display("FAIL tx_basic_status: got %h, required %h", got, exp); end
    endtask

    task automatic test_tx_overflow();
        logic [31:0] got, exp;
        force_busy = 1'b1;
        for (int i = 0; i < 9; i++) begin
            if (i < 8) tx_q.push_back(8'h60 + 8'(i));
            bus_write(REG_TXDATA, 32'h60 + i);
        end
        rd_q.push_back(32'h0008_0015);
        bus_read(REG_STATUS, got); exp = rd_q.pop_front(); tests++;
        if (got !== exp) begin fails++; $display("FAIL tx_ovf_status: got %h, required %h", got, exp); end
        bus_write(REG_STATUS, 32'h10);
        rd_q.push_back(32'h0008_0005);
        bus_read(REG_STATUS, got); exp = rd_q.pop_front(); tests++;
        if (got !== exp) begin fails++; $display("FAIL tx_ovf_clear: got %h, required %h", got, exp); end
        force_busy = 1'b0;
        for (int i = 0; i < 400 && tx_q.size() != 0; i++) @(negedge clk);
        tests++;
        if (tx_q.size() != 0) begin fails++; $display("FAIL tx_ovf_drain: %0d bytes left, required 0", tx_q.size()); end
        repeat (20) @(negedge clk);
    endtask

    task automatic test_rx_irq();
        logic [31:0] got, exp;
        rx_pulse(8'h5A);
        rx_pulse(8'hA5);
        bus_write(REG_CTRL, 32'h1);
        tests++;
        if (irq !== 1'b0) begin fails++; $display("FAIL rx_irq_lag: got %b, required 0", irq); end
        @(negedge clk);
        tests++;
        if (irq !== 1'b1) begin fails++; $display("FAIL rx_irq_rise: got %b, required 1", irq); end
        for (int i = 0; i < 2; i++) begin
            rd_q.push_back({24'h0, rx_q.pop_front()});
            bus_read(REG_RXDATA, got); exp = rd_q.pop_front(); tests++;
            if (got !== exp) begin fails++; $display("FAIL rx_read%0d: got %h, required %h", i, got, exp); end
        end
        @(negedge clk);
        tests++;
        if (irq !== 1'b0) begin fails++; $display("FAIL rx_irq_fall: got %b, required 0", irq); end
        rd_q.push_back(32'h0);
        bus_read(REG_RXDATA, got); exp = rd_q.pop_front(); tests++;
        if (got !== exp) begin fails++; $display("FAIL rx_empty_read: got %h, required %h", got, exp); end
        rd_q.push_back(32'h0000_0046);
        bus_read(REG_STATUS, got); exp = rd_q.pop_front(); tests++;
        if (got !== exp) begin fails++; $display("FAIL rx_unf_status: got %h, required %h", got, exp); end
        bus_write(REG_STATUS, 32'h70);
        bus_write(REG_CTRL, 32'h0);
    endtask

    task automatic test_rx_full();
        logic [31:0] got, exp;
        for (int i = 0; i < 8; i++) rx_pulse(8'h80 + 8'(i));
        // Push and pop together at full.
        @(negedge clk);
        rx_valid = 1'b1; rx_data = 8'h77; sel = 1'b1; rd_en = 1'b1; addr = REG_RXDATA;
        rd_q.push_back({24'h0, rx_q.pop_front()});
        rx_q.push_back(8'h77);
        @(negedge clk);
        rx_valid = 1'b0; sel = 1'b0; rd_en = 1'b0;
        got = data_out; exp = rd_q.pop_front(); tests++;
        if (got !== exp) begin fails++; $display("FAIL rx_full_pop: got %h, required %h", got, exp); end
        rd_q.push_back(32'h0000_080A);
        bus_read(REG_STATUS, got); exp = rd_q.pop_front(); tests++;
        if (got !== exp) begin fails++; $display("FAIL rx_full_nopovf: got %h, required %h", got, exp); end
        @(negedge clk);
        rx_valid = 1'b1; rx_data = 8'h88;
        @(negedge clk);
        rx_valid = 1'b0;
        rd_q.push_back(32'h0000_082A);
        bus_read(REG_STATUS, got); exp = rd_q.pop_front(); tests++;
        if (got !== exp) begin fails++; $display("FAIL rx_ovf_status: got %h, required %h", got, exp); end
        for (int i = 0; i < 8; i++) begin
            rd_q.push_back({24'h0, rx_q.pop_front()});
            bus_read(REG_RXDATA, got); exp = rd_q.pop_front(); tests++;
            if (got !== exp) begin fails++; $display("FAIL rx_drain%0d: got %h, required %h", i, got, exp); end
        end
        bus_write(REG_STATUS, 32'h70);
    endtask

    task automatic test_reset_mid_tx();
        logic [31:0] got, exp;
        int          pulses;
        bus_write(REG_BAUD, 32'h55);
        for (int i = 0; i < 4; i++) begin
            tx_q.push_back(8'h31 + 8'(i));
            bus_write(REG_TXDATA, 32'h31 + i);
        end
        for (int i = 0; i < 40 && tx_busy !== 1'b1; i++) @(negedge clk);
        tests++;
        if (tx_busy !== 1'b1) begin fails++; $display("FAIL mid_busy_wait: tx_busy=%b, required 1", tx_busy); end
        rd_q.push_back(32'h0000_0055);
        bus_read(REG_BAUD, got); exp = rd_q.pop_front(); tests++;
        if (got !== exp) begin fails++; $display("FAIL mid_baud: got %h, required %h", got, exp); end
        #2 n_reset = 1'b0;
        #1;
        tx_q.delete();
        tests++;
        if (tx_start !== 1'b0 || data_out !== 32'h0 || baud_tick_max !== 16'd434 || irq !== 1'b0) begin
            fails++;
            $display("FAIL mid_reset_async: tx_start=%b data_out=%h baud=%0d irq=%b, required 0/0/434/0",
                     tx_start, data_out, baud_tick_max, irq);
        end
        repeat (2) @(negedge clk);
        n_reset = 1'b1;
        pulses = tx_pulses;
        repeat (30) @(negedge clk);
        tests++;
        if (tx_pulses != pulses) begin
            fails++; $display("FAIL mid_no_tx: %0d pulses after reset, required 0", tx_pulses - pulses);
        end
        rd_q.push_back(32'h0000_0006);
        bus_read(REG_STATUS, got); exp = rd_q.pop_front(); tests++;
        if (got !== exp) begin fails++; $display("FAIL mid_status: got %h, required %h", got, exp); end
        tx_q.push_back(8'h55);
        bus_write(REG_TXDATA, 32'h55);
        for (int i = 0; i < 100 && tx_q.size() != 0; i++) @(negedge clk);
        tests++;
        if (tx_q.size() != 0) begin fails++; $display("FAIL mid_new_tx: %0d bytes left, required 0", tx_q.size()); end
        repeat (20) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_regs();
        test_tx_basic();
        test_tx_overflow();
        test_rx_irq();
        test_rx_full();
        test_reset_mid_tx();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mmio_uart_ctrl.md
Name: mmio_uart_ctrl

Overview:
Memory-mapped peripheral responder on the CPU data bus. It occupies the 0x0003_xxxx region and supplies the value for `mmio_data_out`. It converts CPU register reads and writes into UART TX and RX byte traffic, with a TX FIFO, an RX FIFO, status and control registers, a baud divisor register and one interrupt output. The UART core sits on the far side of this block; its tx_start/tx_busy/tx_data_in/rx_data_out signals connect here.

Parameters:
- FIFO_DEPTH, 8, entries per TX and RX FIFO; power of two, minimum 2.
- BAUD_DEFAULT, 16'd434, reset value of the baud divisor.

Ports:
- clk  input  1  system clock.
- n_reset  input  1  asynchronous active-low reset.
- sel  input  1  region hit, address_bus[31:16]==16'h0003.
- rd_en  input  1  bus read strobe.
- wr_en  input  1  bus write strobe.
- addr  input  8  byte offset in region; addr[1:0] ignored.
- data_in  input  32  write data from CPU.
- data_out  output  32  registered read data to CPU.
- tx_start  output  1  one-cycle pulse to UART TX.
- tx_data  output  8  byte to UART TX; valid while tx_start=1.
- tx_busy  input  1  UART TX is shifting.
- rx_valid  input  1  one-cycle pulse; rx_data is valid.
- rx_data  input  8  received byte.
- baud_tick_max  output  16  divisor to UART.
- irq  output  1  level interrupt.

Behaviour:
- Reset (async assert, sync release): data_out=0, tx_start=0, tx_data=0, baud_tick_max=BAUD_DEFAULT, irq=0. Both FIFOs empty, CTRL=0, sticky flags=0, TX FSM=IDLE.
- Bus access: active only when sel=1. Read latency is 1 cycle: data_out updates on the clock edge after sel&rd_en and holds its value otherwise.
- If rd_en and wr_en are both 1: the write takes effect, no read occurs, data_out holds.
- Unmapped offsets read 0; writes to them are ignored.
- 0x00 TXDATA (W): push data_in[7:0] into the TX FIFO.
  - If full, drop the byte and set TX_OVF.
  - Reads return 0.
- 0x04 RXDATA (R): return {24'h0, head} and pop the RX FIFO.
  - If empty, return 0, no pop, set RX_UNF.
  - Writes are ignored.
- 0x08 STATUS (R):
  - bit0 tx_full, bit1 tx_empty, bit2 rx_empty, bit3 rx_full.
  - bit4 TX_OVF, bit5 RX_OVF, bit6 RX_UNF.
  - bit7 tx_active (FSM not IDLE).
  - [15:8] rx_count, [23:16] tx_count; other bits 0.
  - Write: bits 4–6 are write-1-to-clear; other bits are ignored.
- 0x0C CTRL (RW): bit0 rx_irq_en, bit1 tx_irq_en; other bits read 0.
- 0x10 BAUD (RW): [15:0] drive baud_tick_max directly; upper bits read 0.
- RX capture: rx_valid pushes rx_data.
  - If full and no pop this cycle, drop the byte and set RX_OVF.
  - A pop in the same cycle as a push at full: both occur, no overflow.
- TX push and FSM pop in the same cycle at full: both occur, no overflow.
- Sticky-flag priority: a set in the same cycle as a W1C clear wins (flag stays 1).
- TX FSM:
  - IDLE: if TX FIFO not empty and tx_busy=0, pop, latch tx_data, go to START.
  - START: tx_start=1 for exactly one cycle, go to WAIT_BUSY.
  - WAIT_BUSY: wait for tx_busy=1, then go to WAIT_DONE. If tx_busy stays 0 for 4 cycles, go to IDLE (UART accepted and finished, or absent).
  - WAIT_DONE: wait for tx_busy=0, then go to IDLE.
  - Back-to-back bytes: IDLE→START minimum 1 cycle after WAIT_DONE exit.
- irq (registered, 1-cycle lag) = (rx_irq_en & ~rx_empty) | (tx_irq_en & tx_empty & ~tx_active).
- Reset mid-transfer: FSM aborts to IDLE, tx_start drops immediately, FIFO contents are discarded.
- Count widths: $clog2(FIFO_DEPTH)+1 bits, zero-extended into the 8-bit STATUS fields.

Decomposition:
- Package mmio_pkg:
  - register offsets: REG_TXDATA=8'h00, REG_RXDATA=8'h04, REG_STATUS=8'h08, REG_CTRL=8'h0C, REG_BAUD=8'h10.
  - STATUS bit indices.
  - TX FSM state enum {IDLE, START, WAIT_BUSY, WAIT_DONE}.
  - MMIO_REGION=16'h0003.
- Sub-module: sync_fifo (WIDTH, DEPTH; push, pop, din, dout, full, empty, count). Pointer wrap uses an extra MSB. Instantiated twice.

Test Plan:
- Reset with BAUD_DEFAULT=434 → read 0x10 returns 32'h1B2; STATUS returns 32'h0000_0006 (tx_empty, rx_empty); irq=0.
- Write 0x41 then 0x42 to TXDATA; UART model raises tx_busy 2 cycles after each tx_start and holds it 10 cycles → two single-cycle tx_start pulses with tx_data 0x41 then 0x42, in order; final STATUS bit1=1, bit7=0.
- With tx_busy held 1, write 9 bytes (FIFO_DEPTH=8) → STATUS tx_full=1, TX_OVF=1, tx_count=8; write 32'h10 to STATUS → TX_OVF=0, tx_full still 1.
- Pulse rx_valid with 0x5A, 0xA5; CTRL=1 → irq=1 one cycle later. RXDATA reads return 0x5A then 0xA5, each 1 cycle after the strobe. irq falls after the second pop. A third read returns 0 and sets RX_UNF.
- Fill RX FIFO to 8, then drive rx_valid and an RXDATA read in the same cycle → no RX_OVF, rx_count stays 8; rx_valid alone at full → RX_OVF=1, count 8.
- Assert n_reset=0 mid-byte in WAIT_DONE with 3 bytes queued → tx_start=0 and all reset values restored asynchronously; after release, no tx_start until a new TXDATA write.
